// File: rtl/clcd_pkg.sv
// Shared definitions for the HD44780 command sequencer.
//  - State encoding of the sequencer FSM.
//  - Field positions of a 16-bit init-table word {rs, dly_ms[6:0], data[7:0]}.
//  - init_entry(idx): default table word for one index.
//  - init_table_default(): all 16 default words packed, entry i at bits [16*i +: 16].
package clcd_pkg;

  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_HI  = 3'd2;
  localparam logic [2:0] ST_WAIT_LO  = 3'd3;
  localparam logic [2:0] ST_POST_DLY = 3'd4;
  localparam logic [2:0] ST_IDLE     = 3'd5;

  typedef enum logic [2:0] {
    S_PWR_WAIT = ST_PWR_WAIT,
    S_ISSUE    = ST_ISSUE,
    S_WAIT_HI  = ST_WAIT_HI,
    S_WAIT_LO  = ST_WAIT_LO,
    S_POST_DLY = ST_POST_DLY,
    S_IDLE     = ST_IDLE
  } state_e;

  localparam int unsigned ENT_RS_BIT  = 15;
  localparam int unsigned ENT_DLY_HI  = 14;
  localparam int unsigned ENT_DLY_LO  = 8;
  localparam int unsigned ENT_DATA_HI = 7;
  localparam int unsigned ENT_DATA_LO = 0;
  localparam int unsigned TABLE_DEPTH = 16;

  function automatic logic [15:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {1'b0, 7'd5, 8'h03};
      4'd1:    init_entry = {1'b0, 7'd1, 8'h03};
      4'd2:    init_entry = {1'b0, 7'd1, 8'h03};
      4'd3:    init_entry = {1'b0, 7'd1, 8'h02};
      4'd4:    init_entry = {1'b0, 7'd1, 8'h28};
      4'd5:    init_entry = {1'b0, 7'd1, 8'h08};
      4'd6:    init_entry = {1'b0, 7'd2, 8'h01};
      4'd7:    init_entry = {1'b0, 7'd1, 8'h06};
      4'd8:    init_entry = {1'b0, 7'd1, 8'h0F};
      default: init_entry = 16'h0000;
    endcase
  endfunction

  function automatic logic [255:0] init_table_default();
    logic [255:0] t;
    t = 256'd0;
    for (int i = 0; i < 16; i++) begin
      t[i*16 +: 16] = init_entry(4'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/clcd_ms_tick.sv
// Free-running 1 ms strobe generator.
//  clk     in  system clock
//  reset_p in  async active-high reset
//  tick_o  out one-cycle pulse every CLK_HZ/1000 clocks
module clcd_ms_tick #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick_o
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Prescaler: wrap at DIV-1 and emit the strobe on the wrap.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clcd_cmd_sequencer.sv
// Table-driven HD44780 command sequencer. Waits after power-on, replays the init
// table to the transmitter over a valid/busy handshake, then serves user writes.
//  clk, reset_p        clock, async active-high reset
//  i_busy              transmitter busy
//  i_start_init        pulse: rerun power-on wait and the init table
//  i_usr_valid/rs/data user write request
//  o_usr_ready         sequencer idle, request accepted when valid
//  o_data, o_RS, o_RW  byte, register select, write-only flag to transmitter
//  o_valid             transmit request
//  o_empty             init complete (idle or user transaction)
//  o_step              current init-table index
//  o_error             sticky busy-handshake timeout
module clcd_cmd_sequencer
  import clcd_pkg::*;
#(
  parameter int unsigned  CLK_HZ        = 100_000_000,
  parameter int unsigned  POWERON_MS    = 20,
  parameter int unsigned  N_INIT        = 9,
  parameter int unsigned  USR_DELAY_MS  = 1,
  parameter int unsigned  LONG_DELAY_MS = 2,
  parameter int unsigned  TIMEOUT_MS    = 10,
  parameter logic [255:0] INIT_TABLE    = init_table_default()
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_busy,
  input  logic       i_start_init,
  input  logic       i_usr_valid,
  input  logic       i_usr_rs,
  input  logic [7:0] i_usr_data,
  output logic       o_usr_ready,
  output logic [7:0] o_data,
  output logic       o_RS,
  output logic       o_RW,
  output logic       o_valid,
  output logic       o_empty,
  output logic [3:0] o_step,
  output logic       o_error
);

  if (N_INIT < 1 || N_INIT > TABLE_DEPTH) begin : g_n_init_range
    $error("N_INIT must be within 1..16");
  end

  state_e      state_q;
  logic [3:0]  step_q;
  logic [15:0] dly_cnt_q;
  logic        pend_q, user_q, usr_rs_q, rs_q, valid_q, empty_q, usr_ready_q, error_q;
  logic [7:0]  usr_data_q, data_q;
  logic        busy_q, busy_prev_q;

  logic        tick_s, rise_s, fall_s, dly_done_s, long_s;
  logic [15:0] entry_s, target_s;

  clcd_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick_o  (tick_s)
  );

  // Edge detect on the registered busy, table lookup and per-state delay target.
  always_comb begin
    rise_s   = busy_q & ~busy_prev_q;
    fall_s   = ~busy_q & busy_prev_q;
    entry_s  = INIT_TABLE[{step_q, 4'd0} +: 16];
    long_s   = ~usr_rs_q && (usr_data_q == 8'h01 || usr_data_q == 8'h02);
    target_s = 16'd0;
    case (state_q)
      S_PWR_WAIT: target_s = 16'(POWERON_MS);
      S_WAIT_HI,
      S_WAIT_LO:  target_s = 16'(TIMEOUT_MS);
      S_POST_DLY: begin
        if (user_q) begin
          target_s = long_s ? 16'(LONG_DELAY_MS) : 16'(USR_DELAY_MS);
        end else begin
          target_s = {9'd0, entry_s[ENT_DLY_HI:ENT_DLY_LO]};
        end
      end
      default:    target_s = 16'd0;
    endcase
    // Delay of D ms completes on the D-th tick since the counter was cleared.
    dly_done_s = tick_s && ((dly_cnt_q + 16'd1) >= target_s);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_PWR_WAIT;
      step_q      <= 4'd0;
      dly_cnt_q   <= 16'd0;
      pend_q      <= 1'b0;
      user_q      <= 1'b0;
      usr_rs_q    <= 1'b0;
      usr_data_q  <= 8'h00;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      valid_q     <= 1'b0;
      empty_q     <= 1'b0;
      usr_ready_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      busy_q      <= i_busy;
      busy_prev_q <= busy_q;
      if (tick_s) begin
        dly_cnt_q <= dly_cnt_q + 16'd1;
      end
      // Re-init requests during a transaction wait for the end of its post-delay.
      if (i_start_init && state_q != S_IDLE && state_q != S_PWR_WAIT) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        S_PWR_WAIT: begin
          if (i_start_init || pend_q) begin
            dly_cnt_q <= 16'd0;
            step_q    <= 4'd0;
            error_q   <= 1'b0;
            empty_q   <= 1'b0;
            pend_q    <= 1'b0;
          end else if (dly_done_s) begin
            state_q   <= S_ISSUE;
            step_q    <= 4'd0;
            user_q    <= 1'b0;
            dly_cnt_q <= 16'd0;
          end
        end
        S_ISSUE: begin
          data_q    <= user_q ? usr_data_q : entry_s[ENT_DATA_HI:ENT_DATA_LO];
          rs_q      <= user_q ? usr_rs_q : entry_s[ENT_RS_BIT];
          valid_q   <= 1'b1;
          dly_cnt_q <= 16'd0;
          state_q   <= S_WAIT_HI;
        end
        S_WAIT_HI, S_WAIT_LO: begin
          if ((state_q == S_WAIT_HI) && rise_s) begin
            valid_q   <= 1'b0;
            dly_cnt_q <= 16'd0;
            state_q   <= S_WAIT_LO;
          end else if ((state_q == S_WAIT_LO) && fall_s) begin
            dly_cnt_q <= 16'd0;
            state_q   <= S_POST_DLY;
          end else if (dly_done_s) begin
            // Transmitter stuck: flag it and recover through a full re-init.
            error_q   <= 1'b1;
            valid_q   <= 1'b0;
            empty_q   <= 1'b0;
            step_q    <= 4'd0;
            user_q    <= 1'b0;
            dly_cnt_q <= 16'd0;
            state_q   <= S_PWR_WAIT;
          end
        end
        S_POST_DLY: begin
          if (dly_done_s) begin
            dly_cnt_q <= 16'd0;
            if (pend_q || i_start_init) begin
              pend_q  <= 1'b0;
              step_q  <= 4'd0;
              error_q <= 1'b0;
              empty_q <= 1'b0;
              user_q  <= 1'b0;
              state_q <= S_PWR_WAIT;
            end else if (user_q || step_q == 4'(N_INIT - 1)) begin
              user_q      <= 1'b0;
              empty_q     <= 1'b1;
              usr_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              step_q  <= step_q + 4'd1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_IDLE: begin
          if (i_start_init) begin
            usr_ready_q <= 1'b0;
            empty_q     <= 1'b0;
            step_q      <= 4'd0;
            error_q     <= 1'b0;
            dly_cnt_q   <= 16'd0;
            state_q     <= S_PWR_WAIT;
          end else if (i_usr_valid) begin
            usr_rs_q    <= i_usr_rs;
            usr_data_q  <= i_usr_data;
            user_q      <= 1'b1;
            usr_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_PWR_WAIT;
        end
      endcase
    end
  end

  // A same-cycle re-init request pre-empts the user request.
  assign o_usr_ready = usr_ready_q & ~i_start_init;
  assign o_data      = data_q;
  assign o_RS        = rs_q;
  assign o_RW        = 1'b0;
  assign o_valid     = valid_q;
  assign o_empty     = empty_q;
  assign o_step      = step_q;
  assign o_error     = error_q;

endmodule

// File: tb/tb_clcd_cmd_sequencer.sv
module tb_clcd_cmd_sequencer;

  localparam int MS = 100;  // clocks per ms with CLK_HZ = 100_000

  logic       clk = 1'b0;
  logic       reset_p;
  logic       i_busy;
  logic       i_start_init;
  logic       i_usr_valid;
  logic       i_usr_rs;
  logic [7:0] i_usr_data;
  logic       o_usr_ready;
  logic [7:0] o_data;
  logic       o_RS;
  logic       o_RW;
  logic       o_valid;
  logic       o_empty;
  logic [3:0] o_step;
  logic       o_error;

  clcd_cmd_sequencer #(.CLK_HZ(100_000)) dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .i_busy       (i_busy),
    .i_start_init (i_start_init),
    .i_usr_valid  (i_usr_valid),
    .i_usr_rs     (i_usr_rs),
    .i_usr_data   (i_usr_data),
    .o_usr_ready  (o_usr_ready),
    .o_data       (o_data),
    .o_RS         (o_RS),
    .o_RW         (o_RW),
    .o_valid      (o_valid),
    .o_empty      (o_empty),
    .o_step       (o_step),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    last_fall_cyc = 0;
  logic  valid_prev = 1'b0;
  logic  busy_prev  = 1'b0;
  logic  xmit_en    = 1'b1;

  logic [7:0] init_data [9] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h08, 8'h01, 8'h06, 8'h0F};

  // Transmitter model: busy rises 3 clocks after o_valid, stays high 50 clocks.
  initial begin
    i_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && xmit_en) begin
        repeat (3) @(posedge clk);
        #2 i_busy = 1'b1;
        repeat (50) @(posedge clk);
        #2 i_busy = 1'b0;
      end
    end
  end

  // Monitor: capture each transfer request and the time busy falls.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (o_valid && !valid_prev) obs_q.push_back({o_RS, o_data});
    if (!i_busy && busy_prev) last_fall_cyc = cyc;
    valid_prev = o_valid;
    busy_prev  = i_busy;
  end

  task automatic push_init();
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, init_data[i]});
  endtask

  task automatic wait_empty(input string tag);
    int k;
    for (k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (o_empty) break;
    end
    n_checks++;
    if (!o_empty) begin
      n_fail++;
      $display("FAIL %s_empty_timeout: o_empty=%0b, required 1 within 6000 clks", tag, o_empty);
    end
  endtask

  task automatic test_reset();
    xfer_t e, o;
    int t0, k;
    reset_p = 1'b1; i_start_init = 1'b0; i_usr_valid = 1'b0; i_usr_rs = 1'b0; i_usr_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_valid, o_empty, o_usr_ready, o_error, o_RW, o_step, o_data, o_RS} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b empty=%0b ready=%0b err=%0b rw=%0b step=%0d data=%02h rs=%0b, required all 0",
               o_valid, o_empty, o_usr_ready, o_error, o_RW, o_step, o_data, o_RS);
    end
    reset_p = 1'b0;
    t0 = cyc;
    push_init();
    for (k = 0; k < 2500; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    n_checks++;
    if ((cyc - t0) < 19 * MS || (cyc - t0) > 21 * MS) begin
      n_fail++;
      $display("FAIL poweron_wait: first o_valid after %0d clks, required 1900..2100", cyc - t0);
    end
    wait_empty("init");
    n_checks++;
    if ((cyc - last_fall_cyc) < 1 || (cyc - last_fall_cyc) > MS + 10) begin
      n_fail++;
      $display("FAIL init_last_delay: o_empty %0d clks after busy fall, required 1..110", cyc - last_fall_cyc);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL init_xfer: no transfer captured, required rs=%0b data=%02h", e.rs, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL init_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic test_user_write();
    xfer_t e, o;
    int k;
    @(negedge clk);
    n_checks++;
    if (o_usr_ready !== 1'b1) begin
      n_fail++; $display("FAIL usr_ready_idle: got %0b, required 1", o_usr_ready);
    end
    i_usr_valid = 1'b1; i_usr_rs = 1'b1; i_usr_data = 8'h41;
    exp_q.push_back({1'b1, 8'h41});
    @(negedge clk);
    i_usr_valid = 1'b0;
    n_checks++;
    if (o_usr_ready !== 1'b0) begin
      n_fail++; $display("FAIL usr_ready_drop: got %0b, required 0", o_usr_ready);
    end
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (o_usr_ready) break;
    end
    n_checks++;
    if (!o_usr_ready || (cyc - last_fall_cyc) < 1 || (cyc - last_fall_cyc) > MS + 5) begin
      n_fail++; $display("FAIL usr_post_delay: ready=%0b after %0d clks from busy fall, required 1 within 1..105",
                         o_usr_ready, cyc - last_fall_cyc);
    end
    n_checks++;
    if ({o_RS, o_data, o_empty} !== {1'b1, 8'h41, 1'b1}) begin
      n_fail++; $display("FAIL usr_hold: rs=%0b data=%02h empty=%0b, required rs=1 data=41 empty=1", o_RS, o_data, o_empty);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL usr_xfer: no transfer captured, required rs=%0b data=%02h", e.rs, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL usr_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic test_cmd_delays();
    xfer_t e, o;
    logic [7:0] cmds [3] = '{8'h01, 8'h02, 8'h0C};
    int         dly  [3] = '{2, 2, 1};
    int k, d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_usr_valid = 1'b1; i_usr_rs = 1'b0; i_usr_data = cmds[i];
      exp_q.push_back({1'b0, cmds[i]});
      @(negedge clk);
      i_usr_valid = 1'b0;
      for (k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (o_usr_ready) break;
      end
      d = cyc - last_fall_cyc;
      n_checks++;
      if (dly[i] == 2) begin
        if (!o_usr_ready || d < MS + 1 || d > 2 * MS + 10) begin
          n_fail++; $display("FAIL cmd_delay_%02h: ready=%0b after %0d clks, required 1 within 101..210", cmds[i], o_usr_ready, d);
        end
      end else begin
        if (!o_usr_ready || d < 1 || d > MS + 5) begin
          n_fail++; $display("FAIL cmd_delay_%02h: ready=%0b after %0d clks, required 1 within 1..105", cmds[i], o_usr_ready, d);
        end
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL cmd_xfer: no transfer captured, required data=%02h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL cmd_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic test_timeout();
    xfer_t e, o;
    int k, tv;
    xmit_en = 1'b0;
    @(negedge clk);
    i_usr_valid = 1'b1; i_usr_rs = 1'b0; i_usr_data = 8'h80;
    exp_q.push_back({1'b0, 8'h80});
    @(negedge clk);
    i_usr_valid = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    tv = cyc;
    for (k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (o_error) break;
    end
    n_checks++;
    if (!o_error || (cyc - tv) < 9 * MS - 5 || (cyc - tv) > 10 * MS + 10) begin
      n_fail++; $display("FAIL timeout_time: err=%0b after %0d clks, required 1 within 895..1010", o_error, cyc - tv);
    end
    n_checks++;
    if ({o_valid, o_empty, o_step} !== 6'd0) begin
      n_fail++; $display("FAIL timeout_state: valid=%0b empty=%0b step=%0d, required 0 0 0", o_valid, o_empty, o_step);
    end
    xmit_en = 1'b1;
    push_init();
    wait_empty("recover");
    n_checks++;
    if (o_error !== 1'b1) begin
      n_fail++; $display("FAIL error_sticky: got %0b, required 1", o_error);
    end
    i_start_init = 1'b1;
    @(negedge clk);
    i_start_init = 1'b0;
    n_checks++;
    if ({o_error, o_empty} !== 2'b00) begin
      n_fail++; $display("FAIL error_clear: err=%0b empty=%0b, required 0 0", o_error, o_empty);
    end
    push_init();
    wait_empty("clear");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL timeout_xfer: no transfer captured, required data=%02h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL timeout_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic test_init_during_wait_lo();
    xfer_t e, o;
    int k, tf;
    @(negedge clk);
    i_start_init = 1'b1;
    @(negedge clk);
    i_start_init = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_data[i]});
    push_init();
    for (k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (o_step == 4'd3 && i_busy) break;
    end
    repeat (10) @(negedge clk);
    i_start_init = 1'b1;
    @(negedge clk);
    i_start_init = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!i_busy) break;
    end
    tf = cyc;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    n_checks++;
    if (!o_valid || (cyc - tf) < 18 * MS || o_step !== 4'd0) begin
      n_fail++; $display("FAIL reinit_gap: next valid=%0b %0d clks after busy fall, step=%0d, required >=1800 clks step 0",
                         o_valid, cyc - tf, o_step);
    end
    wait_empty("reinit");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL reinit_xfer: no transfer captured, required data=%02h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL reinit_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
  endtask

  task automatic test_init_vs_user_and_reset();
    xfer_t e, o;
    int k;
    @(negedge clk);
    i_start_init = 1'b1; i_usr_valid = 1'b1; i_usr_rs = 1'b1; i_usr_data = 8'h55;
    #1;
    n_checks++;
    if (o_usr_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_vs_init: got %0b, required 0", o_usr_ready);
    end
    @(negedge clk);
    i_start_init = 1'b0; i_usr_valid = 1'b0;
    n_checks++;
    if (o_empty !== 1'b0) begin
      n_fail++; $display("FAIL init_wins_empty: got %0b, required 0", o_empty);
    end
    push_init();
    wait_empty("init_wins");
    @(negedge clk);
    i_usr_valid = 1'b1; i_usr_rs = 1'b1; i_usr_data = 8'h42;
    exp_q.push_back({1'b1, 8'h42});
    @(negedge clk);
    i_usr_valid = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    #1 reset_p = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_empty} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: valid=%0b empty=%0b, required 0 0", o_valid, o_empty);
    end
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL init_wins_xfer: no transfer captured, required rs=%0b data=%02h", e.rs, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL init_wins_xfer: got rs=%0b data=%02h, required rs=%0b data=%02h", o.rs, o.data, e.rs, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL extra_xfers: %0d unexpected transfers, required 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_user_write();
    test_cmd_delays();
    test_timeout();
    test_init_during_wait_lo();
    test_init_vs_user_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
